// File: rtl/wb_cmd_pkg.sv
// rtl/wb_cmd_pkg.sv - shared FSM encoding and counter width for the Wishbone command master
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CYCLE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding command to Wishbone classic initiator with ack timeout
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [7:0]  timeout_cnt_o
);

    // Counter value seen in the last allowed wait cycle; expiry happens at that edge.
    localparam cnt_t WAIT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    cnt_t        wait_cnt_q, wait_cnt_d;
    cnt_t        to_cnt_q, to_cnt_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
            rsp_dat_q  <= '0;
            rsp_err_q  <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            rsp_dat_q  <= rsp_dat_d;
            rsp_err_q  <= rsp_err_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        rsp_dat_d  = rsp_dat_q;
        rsp_err_d  = rsp_err_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d       = cmd_we;
                    sel_d      = cmd_sel;
                    adr_d      = cmd_adr;
                    dat_d      = cmd_dat;
                    wait_cnt_d = '0;
                    state_d    = ST_CYCLE;
                end
            end
            ST_CYCLE: begin
                // Ack is checked first so it wins over a simultaneous expiry.
                if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    rsp_dat_d = 32'h0;
                    rsp_err_d = 1'b1;
                    to_cnt_d  = (to_cnt_q == CNT_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready     = (state_q == ST_IDLE) || wb_rst_i;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_dat       = rsp_dat_q;
    assign rsp_err       = rsp_err_q;
    assign wbm_cyc_o     = (state_q == ST_CYCLE);
    assign wbm_stb_o     = (state_q == ST_CYCLE);
    assign wbm_we_o      = we_q;
    assign wbm_sel_o     = sel_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = dat_q;
    assign timeout_cnt_o = to_cnt_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - randomized self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr, cmd_dat;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic [7:0]  timeout_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_to   = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .timeout_cnt_o(timeout_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            wbm_ack_i = 1'($urandom);
            wbm_dat_i = $urandom;
            @(posedge clk); #1;
            chk("idle_cyc", 32'(wbm_cyc_o), 0);
            chk("idle_rsp_valid", 32'(rsp_valid), 0);
        end
        wbm_ack_i = 1'b0;
    endtask

    // delay = number of no-ack cycles before ack; delay >= T means the responder never acks.
    task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, input int delay, input logic [31:0] rdata,
                           input int bp);
        int          n_cyc;
        logic [31:0] exp_dat;
        logic        exp_err;
        if (delay < T) begin
            n_cyc   = delay + 1;
            exp_err = 1'b0;
            exp_dat = we ? 32'h0 : rdata;
        end else begin
            n_cyc   = T;
            exp_err = 1'b1;
            exp_dat = 32'h0;
            exp_to  = (exp_to == 255) ? 255 : exp_to + 1;
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_we = 1'($urandom); cmd_sel = 4'($urandom); cmd_adr = $urandom; cmd_dat = $urandom;
        for (int n = 0; n < n_cyc; n++) begin
            chk("cyc", 32'(wbm_cyc_o), 1);
            chk("stb", 32'(wbm_stb_o), 1);
            chk("we", 32'(wbm_we_o), 32'(we));
            chk("sel", 32'(wbm_sel_o), 32'(sel));
            chk("adr", wbm_adr_o, adr);
            chk("dat_o", wbm_dat_o, dat);
            chk("cmd_ready_busy", 32'(cmd_ready), 0);
            chk("rsp_valid_early", 32'(rsp_valid), 0);
            wbm_ack_i = (n == delay);
            wbm_dat_i = (n == delay) ? rdata : $urandom;
            @(posedge clk); #1;
        end
        wbm_ack_i = 1'b0;
        chk("cyc_drop", 32'(wbm_cyc_o), 0);
        chk("stb_drop", 32'(wbm_stb_o), 0);
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_dat", rsp_dat, exp_dat);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("timeout_cnt", 32'(timeout_cnt_o), 32'(exp_to));
        for (int k = 0; k < bp; k++) begin
            cmd_valid = 1'b1;
            wbm_ack_i = 1'($urandom);
            wbm_dat_i = $urandom;
            @(posedge clk); #1;
            chk("bp_cmd_ready", 32'(cmd_ready), 0);
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_dat", rsp_dat, exp_dat);
            chk("bp_rsp_err", 32'(rsp_err), 32'(exp_err));
            chk("bp_cyc", 32'(wbm_cyc_o), 0);
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 0);
        chk("post_cmd_ready", 32'(cmd_ready), 1);
        chk("post_cyc", 32'(wbm_cyc_o), 0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
        rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_cyc", 32'(wbm_cyc_o), 0);
        chk("rst_stb", 32'(wbm_stb_o), 0);
        chk("rst_we", 32'(wbm_we_o), 0);
        chk("rst_sel", 32'(wbm_sel_o), 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_dat_o", wbm_dat_o, 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_timeout_cnt", 32'(timeout_cnt_o), 0);
        chk("rst_cmd_ready_run", 32'(cmd_ready), 1);

        idle_gap(2);
        run_txn(1'b0, 4'hF, 32'h3000_0004, 32'h0, 0, 32'hDEAD_BEEF, 0);
        run_txn(1'b1, 4'h3, 32'h3000_0000, 32'h1234_5678, 3, 32'hCAFE_F00D, 0);
        run_txn(1'b0, 4'hF, 32'h3000_0008, 32'h0, T + 2, 32'h5555_AAAA, 0);
        run_txn(1'b0, 4'h1, 32'h3000_000C, 32'h0, 1, 32'hA5A5_0001, 5);
        run_txn(1'b0, 4'h8, 32'h3000_0010, 32'h0, T - 1, 32'h0BAD_CAFE, 1);

        for (int i = 0; i < 40; i++) begin
            idle_gap($urandom_range(0, 2));
            run_txn(1'($urandom), 4'($urandom), $urandom, $urandom,
                    $urandom_range(0, T + 2), $urandom, $urandom_range(0, 3));
        end

        while (exp_to < 255) begin
            run_txn(1'($urandom), 4'($urandom), $urandom, $urandom, T, $urandom, 0);
        end
        run_txn(1'b0, 4'hF, 32'h4000_0000, 32'h0, T, 32'h0, 0);

        // Reset pulsed in the second bus cycle with a command still offered.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0020; cmd_dat = 32'h0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_cyc_before", 32'(wbm_cyc_o), 1);
        rst = 1'b1;
        cmd_valid = 1'b1;
        #1;
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        exp_to = 0;
        chk("rst_mid_cyc", 32'(wbm_cyc_o), 0);
        chk("rst_mid_stb", 32'(wbm_stb_o), 0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_mid_cmd_ready_after", 32'(cmd_ready), 1);
        chk("rst_mid_timeout_cnt", 32'(timeout_cnt_o), 0);
        chk("rst_mid_adr", wbm_adr_o, 0);
        @(posedge clk); #1;
        chk("rst_no_accept_cyc", 32'(wbm_cyc_o), 0);
        chk("rst_no_accept_rsp", 32'(rsp_valid), 0);

        run_txn(1'b0, 4'hF, 32'h3000_0024, 32'h0, 0, 32'h600D_D00D, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of wait cycles for wbm_ack_i before abort (legal range 1..255).
REQ-002 SHALL have port wb_clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port cmd_valid, input, 1, a command offered.
REQ-005 SHALL have port cmd_ready, output, 1, a command accepted when high with cmd_valid.
REQ-006 SHALL have ports cmd_we (input, 1), cmd_sel (input, 4), cmd_adr (input, 32) and cmd_dat (input, 32), the command fields.
REQ-007 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_dat (output, 32) and rsp_err (output, 1), the response channel.
REQ-008 SHALL have ports wbm_cyc_o, wbm_stb_o and wbm_we_o (output, 1 each), wbm_sel_o (output, 4), wbm_adr_o and wbm_dat_o (output, 32 each), the Wishbone initiator outputs.
REQ-009 SHALL have ports wbm_dat_i (input, 32) and wbm_ack_i (input, 1), the Wishbone responder returns.
REQ-010 SHALL have port timeout_cnt_o, output, 8, a saturating count of aborted transactions.

Function
REQ-011 SHALL implement FSM states IDLE, CYCLE and RESP.
REQ-012 IDLE: cmd_ready=1; cmd_valid&cmd_ready latches all cmd fields into the Wishbone output registers and moves to CYCLE on the same edge.
REQ-013 cmd_ready SHALL be 0 in CYCLE and RESP, so at most one command is outstanding.
REQ-014 CYCLE: wbm_cyc_o=wbm_stb_o=1, asserted the first cycle after acceptance (one-cycle issue latency); all wbm_*_o outputs are held stable for the whole cycle.
REQ-015 wbm_ack_i high in CYCLE SHALL, at that edge, deassert cyc/stb, capture rsp_dat=wbm_dat_i for reads or 0 for writes, set rsp_err=0, and enter RESP.
REQ-016 The wait counter SHALL clear on entry to CYCLE and increment each CYCLE cycle without ack.
REQ-017 When the counter reaches TIMEOUT_CYCLES without ack, the block SHALL deassert cyc/stb, set rsp_dat=0 and rsp_err=1, increment timeout_cnt_o (saturating at 255) and enter RESP.
REQ-018 If ack arrives in the same cycle the counter expires, ack SHALL win (normal response, no error).
REQ-019 RESP: rsp_valid=1, with rsp_dat and rsp_err held until rsp_ready=1; then return to IDLE, where cmd_ready=1 the next cycle.
REQ-020 wbm_ack_i outside CYCLE SHALL be ignored.
REQ-021 Minimum read latency SHALL be: accept at edge N, cyc/stb high during N+1, ack at N+1, rsp_valid at N+2.
REQ-022 wbm_adr_o and wbm_sel_o SHALL be passed through unmodified; no alignment checks.

Reset
REQ-023 wb_rst_i high at an edge SHALL force IDLE, cmd_ready=1, and rsp_valid, rsp_err, rsp_dat, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, the wait counter and timeout_cnt_o all to 0.
REQ-024 Reset during CYCLE SHALL drop cyc/stb at that edge; a pending response is discarded.
REQ-025 cmd_ready SHALL be 1 during reset, but no command is accepted while wb_rst_i=1.

Structure
REQ-026 The FSM state encoding and the timeout counter width (8) SHALL reside in shared package wb_cmd_pkg.
REQ-027 The block SHALL be a single module with no sub-modules; the saturating counter is inline.

Verification
REQ-028 Read: cmd adr=0x3000_0004, we=0, sel=0xF; responder acks on the first stb cycle with 0xDEADBEEF -> rsp_valid two cycles after accept, rsp_dat=0xDEADBEEF, rsp_err=0.
REQ-029 Write: adr=0x3000_0000, dat=0x1234_5678, sel=0x3; ack after 3 wait cycles -> wbm_dat_o/sel/we stable throughout, rsp_dat=0, rsp_err=0.
REQ-030 Timeout: TIMEOUT_CYCLES=4, no ack -> cyc drops after 4 CYCLE cycles, rsp_err=1, timeout_cnt_o=1.
REQ-031 Backpressure: rsp_ready held low for 5 cycles while cmd_valid=1 -> cmd_ready=0 and rsp fields stable, accept occurs only after the response handshake.
REQ-032 Reset mid-cycle: wb_rst_i pulsed in the 2nd CYCLE cycle -> cyc/stb=0 next edge, no rsp_valid, cmd_ready=1.
REQ-033 Ack on the expiry cycle (TIMEOUT_CYCLES=4, ack on the 4th wait cycle) -> rsp_err=0, timeout_cnt_o unchanged.
